// File: rtl/sample_strobe_gen_if.sv
// Control/status bundle for sample_strobe_gen: lock input, increment writes,
// per-channel enables and the generated strobes.
interface sample_strobe_gen_if #(
  parameter int NUM_CH = 2,
  parameter int ACC_W  = 32
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic              pll_locked;
  logic [NUM_CH-1:0] ch_enable;
  logic              inc_wr;
  logic [CH_W-1:0]   inc_ch;
  logic [ACC_W-1:0]  inc_data;
  logic              clr_lost;
  logic [NUM_CH-1:0] strobe;
  logic [NUM_CH-1:0] phase_msb;
  logic              ready;
  logic              lock_lost;

  modport master (
    output pll_locked, ch_enable, inc_wr, inc_ch, inc_data, clr_lost,
    input  strobe, phase_msb, ready, lock_lost
  );

  modport slave (
    input  pll_locked, ch_enable, inc_wr, inc_ch, inc_data, clr_lost,
    output strobe, phase_msb, ready, lock_lost
  );
endinterface

// File: rtl/sample_strobe_gen.sv
// Lock-supervised fractional-rate strobe generator: per-channel phase accumulators
// on refclk whose carries become one-cycle sample strobes once the PLL is locked.
module sample_strobe_gen #(
  parameter int NUM_CH      = 2,
  parameter int ACC_W       = 32,
  parameter int HOLDOFF     = 256,
  parameter int SYNC_STAGES = 2
) (
  input  logic                refclk,
  input  logic                rst,
  sample_strobe_gen_if.slave  bus
);
  localparam int HCW = $clog2(HOLDOFF) + 1;

  typedef enum logic [1:0] {WAIT_LOCK, HOLD, RUN} state_t;

  state_t                 state;
  logic [HCW-1:0]         hold_cnt;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   lock_s;
  logic                   ready_q;
  logic                   lock_lost_q;
  logic [NUM_CH-1:0]      strobe_q;
  logic [ACC_W-1:0]       acc [NUM_CH];
  logic [ACC_W-1:0]       inc [NUM_CH];
  logic [ACC_W:0]         sum [NUM_CH];
  logic                   run_adv;

  assign lock_s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], bus.pll_locked};
  end

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state       <= WAIT_LOCK;
      hold_cnt    <= '0;
      ready_q     <= 1'b0;
      lock_lost_q <= 1'b0;
    end else begin
      if (bus.clr_lost) lock_lost_q <= 1'b0;
      case (state)
        WAIT_LOCK: begin
          hold_cnt <= '0;
          if (lock_s) state <= HOLD;
        end
        HOLD: begin
          if (!lock_s) begin
            state    <= WAIT_LOCK;
            hold_cnt <= '0;
          end else if (hold_cnt == HCW'(HOLDOFF - 1)) begin
            state   <= RUN;
            ready_q <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt + HCW'(1);
          end
        end
        RUN: begin
          // A fresh loss beats a simultaneous clear.
          if (!lock_s) begin
            state       <= WAIT_LOCK;
            ready_q     <= 1'b0;
            lock_lost_q <= 1'b1;
          end
        end
        default: begin
          state   <= WAIT_LOCK;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  // The edge that leaves RUN already restarts phase from zero.
  assign run_adv = (state == RUN) && lock_s;

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) sum[i] = {1'b0, acc[i]} + {1'b0, inc[i]};
  end

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) inc[i] <= '0;
    end else if (bus.inc_wr && (int'(bus.inc_ch) < NUM_CH)) begin
      inc[bus.inc_ch] <= bus.inc_data;
    end
  end

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) acc[i] <= '0;
      strobe_q <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (run_adv && bus.ch_enable[i]) begin
          acc[i]      <= sum[i][ACC_W-1:0];
          strobe_q[i] <= sum[i][ACC_W];
        end else if (run_adv) begin
          strobe_q[i] <= 1'b0;
        end else begin
          acc[i]      <= '0;
          strobe_q[i] <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    bus.phase_msb = '0;
    for (int i = 0; i < NUM_CH; i++) bus.phase_msb[i] = acc[i][ACC_W-1];
  end

  assign bus.strobe    = strobe_q;
  assign bus.ready     = ready_q;
  assign bus.lock_lost = lock_lost_q;
endmodule

// File: tb/tb_sample_strobe_gen.sv
// Directed bench for sample_strobe_gen with NUM_CH=3, ACC_W=8, HOLDOFF=4, SYNC_STAGES=2.
module tb_sample_strobe_gen;
  logic refclk;
  logic rst;
  int   checks;
  int   errors;
  int   cnt0;
  int   cnt1;
  logic [7:0] acc1_m;
  logic       c1_m;

  sample_strobe_gen_if #(.NUM_CH(3), .ACC_W(8)) bus ();

  sample_strobe_gen #(
    .NUM_CH(3), .ACC_W(8), .HOLDOFF(4), .SYNC_STAGES(2)
  ) dut (
    .refclk (refclk),
    .rst    (rst),
    .bus    (bus.slave)
  );

  initial refclk = 1'b0;
  always #5 refclk = ~refclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge refclk);
  endtask

  // Channel 1 runs inc=0xCD continuously; this tracks its accumulator.
  task automatic run_tick();
    @(negedge refclk);
    {c1_m, acc1_m} = {1'b0, acc1_m} + 9'h0CD;
  endtask

  initial begin
    checks = 0; errors = 0; cnt0 = 0; cnt1 = 0;
    acc1_m = 8'h00; c1_m = 1'b0;
    rst = 1'b1;
    bus.pll_locked = 1'b0; bus.ch_enable = 3'b000; bus.inc_wr = 1'b0;
    bus.inc_ch = 2'd0; bus.inc_data = 8'h00; bus.clr_lost = 1'b0;
    #1;
    chk("rst_strobe", bus.strobe, 0);
    chk("rst_msb", bus.phase_msb, 0);
    chk("rst_ready", bus.ready, 0);
    chk("rst_lost", bus.lock_lost, 0);

    // Lock-up: ready rises after the 7th edge; incs written while waiting.
    tick();
    rst = 1'b0; bus.pll_locked = 1'b1; bus.ch_enable = 3'b011;
    bus.inc_wr = 1'b1; bus.inc_ch = 2'd0; bus.inc_data = 8'h40;
    for (int n = 1; n <= 7; n++) begin
      tick();
      chk("lockup_ready", bus.ready, (n == 7));
      chk("lockup_strobe", bus.strobe, 0);
      chk("lockup_lost", bus.lock_lost, 0);
      if (n == 1) begin bus.inc_ch = 2'd1; bus.inc_data = 8'hCD; end
      if (n == 2) bus.inc_wr = 1'b0;
    end

    // Rate: ch0 0x40 strobes every 4th RUN edge, ch1 0xCD gives 205 per 256.
    for (int k = 1; k <= 256; k++) begin
      run_tick();
      if (bus.strobe[0]) cnt0++;
      if (bus.strobe[1]) cnt1++;
      if (k <= 16) begin
        chk("rate_s0", bus.strobe[0], (k % 4 == 0));
        chk("rate_msb0", bus.phase_msb[0], ((k % 4) >= 2));
        chk("rate_s1", bus.strobe[1], c1_m);
        chk("rate_s2_inc0", bus.strobe[2], 0);
      end
    end
    chk("rate_cnt0", cnt0, 64);
    chk("rate_cnt1", cnt1, 205);

    // Increment change: acc0 0 -> 0x40, then write 0x80 at edge W.
    run_tick();
    chk("incw_pre_msb0", bus.phase_msb[0], 0);
    bus.inc_wr = 1'b1; bus.inc_ch = 2'd0; bus.inc_data = 8'h80;
    run_tick();
    chk("incw_W_s0", bus.strobe[0], 0);
    chk("incw_W_msb0", bus.phase_msb[0], 1);
    bus.inc_wr = 1'b0;
    run_tick();
    chk("incw_W1_s0", bus.strobe[0], 1);
    chk("incw_W1_msb0", bus.phase_msb[0], 0);
    bus.inc_wr = 1'b1; bus.inc_ch = 2'd3; bus.inc_data = 8'h01;
    run_tick();
    bus.inc_wr = 1'b0;
    chk("badch_a_s0", bus.strobe[0], 0);
    chk("badch_a_msb0", bus.phase_msb[0], 1);
    run_tick();
    chk("badch_b_s0", bus.strobe[0], 1);
    chk("badch_b_s1", bus.strobe[1], c1_m);
    chk("badch_b_s2", bus.strobe[2], 0);
    run_tick();
    chk("badch_c_s0", bus.strobe[0], 0);
    chk("badch_c_msb0", bus.phase_msb[0], 1);
    chk("badch_c_msb1", bus.phase_msb[1], acc1_m[7]);

    // Enable gating with acc0 = 0x80.
    bus.ch_enable = 3'b010;
    for (int n = 0; n < 10; n++) begin
      run_tick();
      chk("gate_s0", bus.strobe[0], 0);
      chk("gate_msb0", bus.phase_msb[0], 1);
      chk("gate_s1", bus.strobe[1], c1_m);
      chk("gate_msb1", bus.phase_msb[1], acc1_m[7]);
    end
    bus.ch_enable = 3'b011;
    run_tick();
    chk("reen_s0", bus.strobe[0], 1);
    chk("reen_msb0", bus.phase_msb[0], 0);
    run_tick();
    chk("reen2_s0", bus.strobe[0], 0);
    chk("reen2_msb0", bus.phase_msb[0], 1);

    // Lock loss in RUN: third edge drops ready and flags loss.
    bus.pll_locked = 1'b0;
    tick();
    chk("loss_e1_ready", bus.ready, 1);
    tick();
    chk("loss_e2_ready", bus.ready, 1);
    tick();
    chk("loss_ready", bus.ready, 0);
    chk("loss_lost", bus.lock_lost, 1);
    chk("loss_msb", bus.phase_msb, 0);
    chk("loss_strobe", bus.strobe, 0);
    bus.clr_lost = 1'b1;
    tick();
    bus.clr_lost = 1'b0;
    chk("clr_lost", bus.lock_lost, 0);

    // Loss during HOLDOFF is not flagged.
    bus.pll_locked = 1'b1;
    tick(); tick(); tick();
    bus.pll_locked = 1'b0;
    for (int n = 0; n < 6; n++) begin
      tick();
      chk("hold_drop_ready", bus.ready, 0);
      chk("hold_drop_lost", bus.lock_lost, 0);
    end

    // Re-lock, then loss on the same edge as clr_lost: set wins.
    bus.pll_locked = 1'b1;
    for (int n = 1; n <= 7; n++) begin
      tick();
      chk("relock_ready", bus.ready, (n == 7));
    end
    bus.pll_locked = 1'b0;
    tick(); tick();
    bus.clr_lost = 1'b1;
    tick();
    bus.clr_lost = 1'b0;
    chk("setclr_ready", bus.ready, 0);
    chk("setclr_lost", bus.lock_lost, 1);
    tick();
    chk("setclr_sticky", bus.lock_lost, 1);

    // Async reset mid-run.
    bus.pll_locked = 1'b1;
    for (int n = 1; n <= 7; n++) begin
      tick();
      chk("relock2_ready", bus.ready, (n == 7));
    end
    chk("relock2_lost_sticky", bus.lock_lost, 1);
    tick();
    chk("prerst_msb0", bus.phase_msb[0], 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_strobe", bus.strobe, 0);
    chk("arst_msb", bus.phase_msb, 0);
    chk("arst_ready", bus.ready, 0);
    chk("arst_lost", bus.lock_lost, 0);
    tick();
    rst = 1'b0;
    for (int n = 1; n <= 7; n++) begin
      tick();
      chk("postrst_ready", bus.ready, (n == 7));
    end
    for (int n = 0; n < 8; n++) begin
      tick();
      chk("postrst_strobe", bus.strobe, 0);
      chk("postrst_msb", bus.phase_msb, 0);
    end
    bus.inc_wr = 1'b1; bus.inc_ch = 2'd0; bus.inc_data = 8'h40;
    tick();
    bus.inc_wr = 1'b0;
    chk("rewr_W_s0", bus.strobe[0], 0);
    for (int j = 1; j <= 4; j++) begin
      tick();
      chk("rewr_s0", bus.strobe[0], (j == 4));
      chk("rewr_s1", bus.strobe[1], 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
